// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master drives op/a/b/in_valid/out_ready; slave returns result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  carry, overflow, zero, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output carry, overflow, zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: registered single-cycle ops plus a WIDTH-cycle shift-add mul.
// Ports: clk, rst (sync, active high), bus (alu_seq_if.slave: op/a/b in, result/flags out).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_ovf;
  logic               r_zero;
  logic               r_illegal;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_cnt;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_prod_nxt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_ill;

  assign w_in_ready = (r_state == S_IDLE) ||
                      ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.op == 4'd8);
  assign w_mul_last = (r_state == S_BUSY) &&
                      (r_cnt == SHW'(WIDTH - 1));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_is_mul ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_mul_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (!bus.in_valid)
            w_next = S_IDLE;
          else
            w_next = w_is_mul ? S_BUSY : S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} + {1'b0, ~bus.b} +
                  (WIDTH+1)'(1);
  assign w_amt  = bus.b[SHW-1:0];

  assign w_add_ovf =
    (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
    (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
  // a - b overflows when signs differ and
  // the difference takes b's sign.
  assign w_sub_ovf =
    (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
    (w_diff[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    unique case (bus.op)
      4'd0: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_ovf;
      end
      4'd1: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_ovf;
      end
      4'd2: w_res = ~bus.a;
      4'd3: w_res = bus.a & bus.b;
      4'd4: w_res = bus.a | bus.b;
      4'd5: w_res = bus.a ^ bus.b;
      4'd6: begin
        w_res = {{(WIDTH-1){1'b0}},
                 w_diff[WIDTH-1] ^ w_sub_ovf};
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_ovf;
      end
      4'd7: begin
        w_res = {{(WIDTH-1){1'b0}},
                 w_diff[WIDTH-1:0] == '0};
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_ovf;
      end
      // mul result comes from the iterative datapath
      4'd8: w_res = '0;
      4'd9:  w_res = bus.a << w_amt;
      4'd10: w_res = bus.a >> w_amt;
      4'd11: w_res = $unsigned($signed(bus.a) >>> w_amt);
      default: w_ill = 1'b1;
    endcase
  end

  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= {{WIDTH{1'b0}}, bus.a};
        r_mplier <= bus.b;
        r_prod   <= '0;
        r_cnt    <= '0;
      end else begin
        r_result  <= w_res;
        r_carry   <= w_c;
        r_ovf     <= w_v;
        r_zero    <= (w_res == '0);
        r_illegal <= w_ill;
      end
    end else if (r_state == S_BUSY) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_nxt;
      r_cnt    <= r_cnt + SHW'(1);
      if (w_mul_last) begin
        r_result  <= w_prod_nxt[WIDTH-1:0];
        r_carry   <= |w_prod_nxt[2*WIDTH-1:WIDTH];
        r_ovf     <= 1'b0;
        r_zero    <= (w_prod_nxt[WIDTH-1:0] == '0);
        r_illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=32.
// Driver pushes expected results; negedge monitors pop on each output handshake.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(32)) b32 ();

  alu_seq #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );
  alu_seq #(.WIDTH(32)) u32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        il;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   pop8[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] r,
                              input logic c, v, z, il);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.v   = v;
    e.z   = z;
    e.il  = il;
    return e;
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected8: got result %h, expected none",
                 b8.result);
      end else begin
        e = q8.pop_front();
        chk("res8", 32'(b8.result), e.res);
        chk("flags8 c/v/z/il",
            32'({b8.carry, b8.overflow, b8.zero, b8.illegal}),
            32'({e.c, e.v, e.z, e.il}));
      end
      pop8.push_back(cyc);
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected32: got result %h, expected none",
                 b32.result);
      end else begin
        e = q32.pop_front();
        chk("res32", b32.result, e.res);
        chk("flags32 c/v/z/il",
            32'({b32.carry, b32.overflow, b32.zero, b32.illegal}),
            32'({e.c, e.v, e.z, e.il}));
      end
    end
  end

  task automatic issue8(input logic [3:0] op,
                        input logic [7:0] a, b,
                        input logic push, input exp_t e);
    int n;
    b8.op = op;
    b8.a = a;
    b8.b = b;
    b8.in_valid = 1'b1;
    if (push) q8.push_back(e);
    #1;
    n = 0;
    while (!b8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b8.in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept8: in_ready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [3:0] op,
                         input logic [31:0] a, b,
                         input exp_t e);
    int n;
    b32.op = op;
    b32.a = a;
    b32.b = b;
    b32.in_valid = 1'b1;
    q32.push_back(e);
    #1;
    n = 0;
    while (!b32.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b32.in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept32: in_ready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  exp_t none;
  int   base;
  int   n;

  initial begin
    none = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    b8.in_valid = 1'b0;
    b8.op = 4'd0;
    b8.a = '0;
    b8.b = '0;
    b8.out_ready = 1'b1;
    b32.in_valid = 1'b0;
    b32.op = 4'd0;
    b32.a = '0;
    b32.b = '0;
    b32.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst in_ready", 32'(b8.in_ready), 32'd1);
    chk("rst result", 32'(b8.result), 32'd0);
    chk("rst flags",
        32'({b8.carry, b8.overflow, b8.zero, b8.illegal}), 32'd0);
    rst = 1'b0;

    issue8(4'd0, 8'h7F, 8'h01, 1'b1, mk(32'h80, 0, 1, 0, 0));
    chk("add latency out_valid", 32'(b8.out_valid), 32'd1);
    issue8(4'd0, 8'hFF, 8'h01, 1'b1, mk(32'h00, 1, 0, 1, 0));

    issue8(4'd6, 8'h80, 8'h01, 1'b1, mk(32'h01, 1, 1, 0, 0));
    issue8(4'd7, 8'h5A, 8'h5A, 1'b1, mk(32'h01, 1, 0, 0, 0));
    issue8(4'd1, 8'h00, 8'h01, 1'b1, mk(32'hFF, 0, 0, 0, 0));
    issue8(4'd11, 8'h90, 8'hF3, 1'b1, mk(32'hF2, 0, 0, 0, 0));
    issue8(4'd10, 8'h90, 8'hF3, 1'b1, mk(32'h12, 0, 0, 0, 0));
    issue8(4'd9, 8'h81, 8'h01, 1'b1, mk(32'h02, 0, 0, 0, 0));
    issue8(4'd11, 8'h90, 8'h00, 1'b1, mk(32'h90, 0, 0, 0, 0));
    issue8(4'd5, 8'hF0, 8'h3C, 1'b1, mk(32'hCC, 0, 0, 0, 0));

    issue8(4'd8, 8'h10, 8'h11, 1'b1, mk(32'h10, 1, 0, 0, 0));
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("mul busy in_ready", 32'(b8.in_ready), 32'd0);
      chk("mul busy out_valid", 32'(b8.out_valid), 32'd0);
      b8.op = 4'd0;
      b8.a = 8'h01;
      b8.b = 8'h01;
      b8.in_valid = (j < 7);
    end
    @(negedge clk);
    chk("mul latency out_valid", 32'(b8.out_valid), 32'd1);
    @(posedge clk);
    #1;

    b8.out_ready = 1'b0;
    issue8(4'd0, 8'h33, 8'h44, 1'b1, mk(32'h77, 0, 0, 0, 0));
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("hold out_valid", 32'(b8.out_valid), 32'd1);
      chk("hold result", 32'(b8.result), 32'h77);
      chk("hold flags",
          32'({b8.carry, b8.overflow, b8.zero, b8.illegal}), 32'd0);
    end
    @(posedge clk);
    #1;
    b8.out_ready = 1'b1;
    base = pop8.size();
    issue8(4'd0, 8'h01, 8'h02, 1'b1, mk(32'h03, 0, 0, 0, 0));
    issue8(4'd0, 8'h10, 8'h20, 1'b1, mk(32'h30, 0, 0, 0, 0));
    issue8(4'd0, 8'h80, 8'h80, 1'b1, mk(32'h00, 1, 1, 1, 0));
    issue8(4'd0, 8'h7F, 8'h7F, 1'b1, mk(32'hFE, 0, 1, 0, 0));
    @(negedge clk);
    @(negedge clk);
    chk("stream count", 32'(pop8.size() - base), 32'd5);
    if (pop8.size() - base == 5) begin
      for (int i = 1; i < 5; i++)
        chk("stream gap", 32'(pop8[base+i] - pop8[base+i-1]), 32'd1);
    end

    issue8(4'd13, 8'h55, 8'hAA, 1'b1, mk(32'h00, 0, 0, 1, 1));
    issue8(4'd15, 8'h00, 8'h00, 1'b1, mk(32'h00, 0, 0, 1, 1));
    issue8(4'd4, 8'h00, 8'h00, 1'b1, mk(32'h00, 0, 0, 1, 0));
    repeat (2) @(negedge clk);

    issue8(4'd8, 8'h10, 8'h11, 1'b0, none);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-mul rst out_valid", 32'(b8.out_valid), 32'd0);
    chk("mid-mul rst in_ready", 32'(b8.in_ready), 32'd1);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post rst out_valid", 32'(b8.out_valid), 32'd0);
    chk("post rst in_ready", 32'(b8.in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue32(4'd8, 32'hFFFF_FFFF, 32'h2,
            mk(32'hFFFF_FFFE, 1, 0, 0, 0));
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      chk("mul32 busy out_valid", 32'(b32.out_valid), 32'd0);
      chk("mul32 busy in_ready", 32'(b32.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("mul32 latency out_valid", 32'(b32.out_valid), 32'd1);
    @(posedge clk);
    #1;
    issue32(4'd0, 32'h7FFF_FFFF, 32'h1,
            mk(32'h8000_0000, 0, 1, 0, 0));
    issue32(4'd11, 32'h8000_0000, 32'hFFFF_FFFF,
            mk(32'hFFFF_FFFF, 0, 0, 0, 0));

    n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q32.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: %0d/%0d results outstanding, required 0",
               q8.size(), q32.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
